// File: rtl/ultrasonic_ranger_if.sv
// ultrasonic_ranger_if: sensor pins and measurement results for the HC-SR04 front-end.
// master = ranger side (drives trigger and results), slave = sensor/consumer side.
interface ultrasonic_ranger_if;
    logic       echo;
    logic       trigger;
    logic [8:0] distance_cm;
    logic       dist_valid;
    logic       timeout;
    logic       proxim;

    modport master (
        input  echo,
        output trigger,
        output distance_cm,
        output dist_valid,
        output timeout,
        output proxim
    );

    modport slave (
        output echo,
        input  trigger,
        input  distance_cm,
        input  dist_valid,
        input  timeout,
        input  proxim
    );
endinterface

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: periodic HC-SR04 trigger, echo width timing in whole cm,
// distance/timeout publication and a registered near-obstacle flag.
// Optional feature macro: PROXIM_HYST_EN -- proxim releases only once the
// distance reaches NEAR_CM + HYST_CM (or the measurement times out).
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES         = 1000,
    parameter int PERIOD_CYCLES       = 6_000_000,
    parameter int ECHO_TIMEOUT_CYCLES = 3_000_000,
    parameter int CYCLES_PER_CM       = 5800,
    parameter int NEAR_CM             = 20,
    parameter int HYST_CM             = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ultrasonic_ranger_if.master  bus
);
    localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = (ECHO_TIMEOUT_CYCLES > 2) ? $clog2(ECHO_TIMEOUT_CYCLES) : 1;
    localparam int SW = (CYCLES_PER_CM > 2) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [PW-1:0] TRIG_LAST = PW'(TRIG_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(CYCLES_PER_CM - 1);
    localparam logic [8:0]    CM_MAX    = 9'd511;
    localparam logic [15:0]   NEAR_TH   = 16'(NEAR_CM);
    localparam logic [15:0]   REL_TH    = 16'(NEAR_CM + HYST_CM);

`ifdef PROXIM_HYST_EN
    localparam logic HYST_ON = 1'b1;
`else
    localparam logic HYST_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [8:0]    cm_q, cm_d;
    logic          to_flag_q, to_flag_d;
    logic          cnt_en;

    logic          echo_meta_q, echo_s_q, echo_dly_q;
    logic          echo_rise, echo_fall;

    logic          trigger_q;
    logic [8:0]    distance_q;
    logic          dist_valid_q;
    logic          timeout_q;
    logic          proxim_q, proxim_d;
    logic          is_near, is_far;

    // Two-flop synchroniser for the asynchronous echo plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_dly_q  <= 1'b0;
        end else begin
            echo_meta_q <= bus.echo;
            echo_s_q    <= echo_meta_q;
            echo_dly_q  <= echo_s_q;
        end
    end

    assign echo_rise = echo_s_q & ~echo_dly_q;
    assign echo_fall = ~echo_s_q & echo_dly_q;

    // FSM and counter state registers; reset parks the period counter at its
    // last value so the first trigger follows immediately after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            per_cnt_q <= PER_LAST;
            to_cnt_q  <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            to_cnt_q  <= to_cnt_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            to_flag_q <= to_flag_d;
        end
    end

    // Next-state logic; the period counter doubles as the trigger-width timer
    // because it restarts from zero on entry to TRIG
    always_comb begin
        state_d   = state_q;
        per_cnt_d = (per_cnt_q == PER_LAST) ? per_cnt_q : per_cnt_q + 1'b1;
        to_cnt_d  = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + 1'b1;
        sub_d     = sub_q;
        cm_d      = cm_q;
        to_flag_d = to_flag_q;
        cnt_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (per_cnt_q == PER_LAST) begin
                    state_d   = S_TRIG;
                    per_cnt_d = '0;
                end
            end
            S_TRIG: begin
                if (per_cnt_q == TRIG_LAST) begin
                    state_d   = S_WAIT_RISE;
                    to_cnt_d  = '0;
                    sub_d     = '0;
                    cm_d      = '0;
                    to_flag_d = 1'b0;
                end
            end
            S_WAIT_RISE: begin
                // The rising-edge cycle already has echo high, so count it too;
                // this makes the measured width equal the synchronised width.
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    cnt_en  = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    to_flag_d = 1'b1;
                end
            end
            S_MEASURE: begin
                cnt_en = echo_s_q;
                // A falling edge coinciding with timeout yields a normal result
                if (echo_fall) begin
                    state_d = S_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    to_flag_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cnt_en) begin
            if (sub_q == SUB_LAST) begin
                sub_d = '0;
                if (cm_q != CM_MAX) begin
                    cm_d = cm_q + 1'b1;
                end
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    // Near/far decision for the proxim flag; with hysteresis disabled the
    // hold term is masked off and proxim is a plain threshold compare
    always_comb begin
        is_near  = !to_flag_q && (16'(cm_q) < NEAR_TH);
        is_far   = to_flag_q || (16'(cm_q) >= REL_TH);
        proxim_d = is_near | (HYST_ON & ~is_far & proxim_q);
    end

    // Registered outputs; all results update together on the edge that raises dist_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_q    <= 1'b0;
            distance_q   <= '0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            proxim_q     <= 1'b0;
        end else begin
            trigger_q    <= (state_q == S_TRIG);
            dist_valid_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                distance_q <= to_flag_q ? CM_MAX : cm_q;
                timeout_q  <= to_flag_q;
                proxim_q   <= proxim_d;
            end
        end
    end

    assign bus.trigger     = trigger_q;
    assign bus.distance_cm = distance_q;
    assign bus.dist_valid  = dist_valid_q;
    assign bus.timeout     = timeout_q;
    assign bus.proxim      = proxim_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed checks of ultrasonic_ranger with scaled-down
// timing (10 clk/cm, 1000-cycle timeout, 1200-cycle period).
module tb_ultrasonic_ranger;
    localparam int TRIG = 10;
    localparam int PER  = 1200;
    localparam int TO   = 1000;
    localparam int CPC  = 10;
    localparam int NEAR = 20;
    localparam int HYST = 5;

`ifdef PROXIM_HYST_EN
    localparam int HY = 1;
`else
    localparam int HY = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ultrasonic_ranger_if bus ();

    ultrasonic_ranger #(
        .TRIG_CYCLES         (TRIG),
        .PERIOD_CYCLES       (PER),
        .ECHO_TIMEOUT_CYCLES (TO),
        .CYCLES_PER_CM       (CPC),
        .NEAR_CM             (NEAR),
        .HYST_CM             (HYST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int prev_rise = -1;

    // free-running cycle count for latency/period checks
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur(input int which);
        return (which == 0) ? bus.trigger : bus.dist_valid;
    endfunction

    // wait (bounded) until trigger (0) or dist_valid (1) reaches lvl; n = ticks waited
    task automatic wait_for(input string tag, input int which, input logic lvl, output int n);
        n = 0;
        while (cur(which) !== lvl && n < 3 * PER) begin
            tick();
            n++;
        end
        if (cur(which) !== lvl) chk({tag, "_bound"}, 32'(n), 32'(0));
    endtask

    function automatic logic [12:0] outs();
        return {bus.trigger, bus.distance_cm, bus.dist_valid, bus.timeout, bus.proxim};
    endfunction

    // release reset: trigger rises on edge 2, echo-low cycle times out at fall+TO
    task automatic reset_release(input string tag);
        int n, t_rel, t_fall;
        @(posedge clk);
        #1 rst_n = 1'b1;
        t_rel = cyc;
        tick();
        chk({tag, "_trig_e1"}, 32'(bus.trigger), 32'(0));
        tick();
        chk({tag, "_trig_e2"}, 32'(bus.trigger), 32'(1));
        prev_rise = cyc;
        wait_for({tag, "_fall"}, 0, 1'b0, n);
        chk({tag, "_trig_w"}, 32'(n), 32'(TRIG));
        t_fall = cyc;
        wait_for({tag, "_dv"}, 1, 1'b1, n);
        chk({tag, "_to_lat"}, 32'(cyc - t_fall), 32'(TO));
        chk({tag, "_first_dv"}, 32'(cyc - t_rel), 32'(TRIG + 2 + TO));
        chk({tag, "_cm"}, 32'(bus.distance_cm), 32'(511));
        chk({tag, "_to"}, 32'(bus.timeout), 32'(1));
        chk({tag, "_px"}, 32'(bus.proxim), 32'(0));
    endtask

    // one trigger period; width<0 = echo stuck high, width==0 = no echo
    task automatic measure(input string tag, input int width, input int e_cm,
                           input int e_to, input int e_px);
        int n, t_fall;
        if (width < 0) bus.echo = 1'b1;
        wait_for({tag, "_rise"}, 0, 1'b1, n);
        if (prev_rise >= 0) chk({tag, "_period"}, 32'(cyc - prev_rise), 32'(PER));
        prev_rise = cyc;
        wait_for({tag, "_fall"}, 0, 1'b0, n);
        chk({tag, "_trig_w"}, 32'(n), 32'(TRIG));
        t_fall = cyc;
        if (width > 0) begin
            repeat (20) tick();
            bus.echo = 1'b1;
            repeat (width) tick();
            bus.echo = 1'b0;
        end
        wait_for({tag, "_dv"}, 1, 1'b1, n);
        if (width <= 0) chk({tag, "_to_lat"}, 32'(cyc - t_fall), 32'(TO));
        chk({tag, "_cm"}, 32'(bus.distance_cm), 32'(e_cm));
        chk({tag, "_to"}, 32'(bus.timeout), 32'(e_to));
        chk({tag, "_px"}, 32'(bus.proxim), 32'(e_px));
        tick();
        chk({tag, "_dv_1cyc"}, 32'(bus.dist_valid), 32'(0));
        chk({tag, "_cm_hold"}, 32'(bus.distance_cm), 32'(e_cm));
        bus.echo = 1'b0;
    endtask

    initial begin
        int n;
        bus.echo = 1'b0;
        repeat (3) tick();
        chk("rst_outs", 32'(outs()), 32'(0));

        reset_release("rst1");

        measure("w200", 200, 20, 0, 0);
        measure("w190", 190, 19, 0, 1);
        measure("w9",   9,   0,  0, 1);
        measure("w10",  10,  1,  0, 1);
        measure("s19",  190, 19, 0, 1);
        measure("s22",  220, 22, 0, HY);
        measure("s24",  240, 24, 0, HY);
        measure("s25",  250, 25, 0, 0);
        measure("noecho", 0, 511, 1, 0);
        measure("w190b", 190, 19, 0, 1);
        measure("stuck", -1, 511, 1, 0);
        measure("w30",  300, 30, 0, 0);
        measure("w190c", 190, 19, 0, 1);

        // abort a 20 cm measurement 50 cycles into the echo
        wait_for("mid_rise", 0, 1'b1, n);
        wait_for("mid_fall", 0, 1'b0, n);
        repeat (20) tick();
        bus.echo = 1'b1;
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'(outs()), 32'(0));
        bus.echo = 1'b0;
        repeat (5) tick();
        chk("mid_rst_hold", 32'(outs()), 32'(0));
        reset_release("rst2");

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Front-end for the HC-SR04 ultrasonic sensor on the rover. It periodically fires the trigger pulse, times the echo pulse in whole centimetres, and publishes a distance plus a registered near-obstacle flag. The near flag drives the `proxim` input of the motor controller, which decides when to stop. It sits directly upstream of that controller.

## Interface
Parameters:
- `TRIG_CYCLES`, 1000: trigger pulse width in clk cycles (10 µs at 100 MHz).
- `PERIOD_CYCLES`, 6_000_000: trigger-to-trigger period (60 ms).
- `ECHO_TIMEOUT_CYCLES`, 3_000_000: timeout window, measured from the trigger falling edge (30 ms).
- `CYCLES_PER_CM`, 5800: echo-high cycles per centimetre (58 µs).
- `NEAR_CM`, 20: near threshold in cm.
- `HYST_CM`, 5: release margin; used only with `PROXIM_HYST_EN`.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `echo`, input, 1: sensor echo. It is asynchronous to `clk` and is double-flop synchronised inside the block.
- `trigger`, output, 1: sensor trigger pulse.
- `distance_cm`, output, 9: last measured distance. Floor division, saturates at 511.
- `dist_valid`, output, 1: one-cycle strobe when `distance_cm` updates.
- `timeout`, output, 1: set if the last measurement timed out; updated with `dist_valid`.
- `proxim`, output, 1: obstacle-near flag.

## Operation
- Echo synchronisation:
  - Two flops produce `echo_s`; a third flop holds `echo_s` delayed one cycle.
  - Rising edge = `echo_s` high and delayed copy low.
  - Falling edge = `echo_s` low and delayed copy high.
- A period counter runs continuously, resets to 0 on entry to TRIG, and saturates at `PERIOD_CYCLES-1`.
- IDLE: leave for TRIG when the period counter reaches `PERIOD_CYCLES-1`.
- TRIG: hold `trigger`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE.
  - The timeout counter and the cm/sub-cycle counters clear on entry to WAIT_RISE.
- WAIT_RISE: on an echo rising edge, go to MEASURE; if the timeout counter reaches `ECHO_TIMEOUT_CYCLES-1`, go to DONE with the timeout flag set.
  - Echo already high on entry (stuck high) shows no rising edge and therefore times out.
- MEASURE: each cycle with `echo_s` high, increment the sub-counter.
  - When the sub-counter reaches `CYCLES_PER_CM-1`, wrap it to 0 and increment the cm counter. The cm counter saturates at 511.
  - On an echo falling edge, go to DONE with the timeout flag clear.
  - On timeout (same counter as WAIT_RISE, which keeps running), go to DONE with the timeout flag set.
- DONE (one cycle), then IDLE:
  - Normal completion: `distance_cm` ← cm counter.
  - Timeout: `distance_cm` ← 511 and `timeout` ← 1.
  - `dist_valid` ← 1 in both cases.
- `proxim` without `PROXIM_HYST_EN`: updated in DONE to (!timeout && cm < `NEAR_CM`).
- Simultaneous falling edge and timeout in MEASURE: the falling edge wins, giving a normal result.
- Parameter constraint: `TRIG_CYCLES` + `ECHO_TIMEOUT_CYCLES` + 4 < `PERIOD_CYCLES`. This guarantees DONE precedes the next trigger.

## Timing
- Reset values:
  - `trigger`=0, `distance_cm`=0, `dist_valid`=0, `timeout`=0, `proxim`=0.
  - FSM in IDLE with the period counter at `PERIOD_CYCLES-1`.
  - The first trigger therefore rises on the second clk edge after `rst_n` deasserts.
- Trigger rising edges are exactly `PERIOD_CYCLES` apart, independent of echo behaviour.
- Echo-to-state latency is 3 cycles (2 sync flops plus the edge register).
  - Measured width equals the true width ±1 cycle.
- `distance_cm`, `timeout` and `proxim` all change on the same edge that raises `dist_valid`. They hold their values until the next DONE.
- Reset asserted mid-measurement:
  - Outputs return to reset values immediately (asynchronous).
  - No `dist_valid` is produced for the aborted cycle.

## Configuration
- `PROXIM_HYST_EN` defined:
  - `proxim` sets in DONE when (!timeout && cm < `NEAR_CM`).
  - It clears only when timeout or cm ≥ `NEAR_CM` + `HYST_CM`.
  - Otherwise it holds.
- `PROXIM_HYST_EN` undefined: plain threshold compare as in Operation; `HYST_CM` is unused.

## Test plan
- Reset release, echo held low:
  - trigger high for 1000 cycles starting at cycle 2.
  - At trigger fall + 3_000_000 cycles: `dist_valid` pulse, `distance_cm`=511, `timeout`=1, `proxim`=0.
- Echo high for 116_000 cycles, 200 cycles after trigger fall → `distance_cm`=20, `timeout`=0, `proxim`=0.
- Echo high for 110_200 cycles → `distance_cm`=19, `proxim`=1.
- Echo high for 5_799 cycles → `distance_cm`=0, `proxim`=1.
- Echo high for 5_800 cycles → `distance_cm`=1 (±1 cycle tolerance at the boundary).
- With `PROXIM_HYST_EN`:
  - Measurement sequence 19, 22, 24, 25 cm → `proxim` 1, 1, 1, 0.
  - Without the macro, the same sequence → 1, 0, 0, 0.
- Assert `rst_n` low 50_000 cycles into a 116_000-cycle echo:
  - All outputs are 0 at once.
  - After release, the next trigger rises at cycle 2 and no stale `dist_valid` appears.
